// File: rtl/read_port_adapter.sv
// read_port_adapter: bridges a valid/ready read-request stream onto a fixed
// latency memory read port and returns the read data as a valid/ready
// response stream. A credit counter (pending) caps reads in flight plus
// buffered responses at FIFO_DEPTH, so the response FIFO cannot overflow.
// Optional cut-through path: define READ_PORT_ADAPTER_BYPASS_EN to let
// returning data reach rsp_* in the return cycle when the FIFO is empty.
module read_port_adapter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        aclk,
    input  logic                        srst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_WIDTH-1:0]       req_addr,
    output logic                        rden,
    output logic [ADDR_WIDTH-1:0]       rdaddr,
    input  logic [DATA_WIDTH-1:0]       rddata,
    input  logic [1:0]                  rdcollision,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic [1:0]                  rsp_collision,
    output logic [$clog2(FIFO_DEPTH):0] pending
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IW = PW - 1;
    localparam int unsigned EW = DATA_WIDTH + 2;
    localparam logic [PW-1:0] DEPTH_CNT = PW'(FIFO_DEPTH);

    logic [PW-1:0]         pending_q, pending_d;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]         mem_q [FIFO_DEPTH];

    logic          accept;
    logic          ret;
    logic [EW-1:0] ret_data;
    logic [EW-1:0] head;
    logic          empty;
    logic          full;
    logic          push;
    logic          push_ok;
    logic          fifo_pop;
    logic          rsp_pop;

    // Request side: credit check and direct drive of the memory read port.
    always_comb begin
        req_ready = (pending_q < DEPTH_CNT);
        accept    = req_valid && req_ready;
        rden      = accept;
        rdaddr    = req_addr;
        pending   = pending_q;
    end

    // Read-valid shift register tracking each issued read to its data return.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = accept;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        ret      = vld_q[RD_LATENCY-1];
        ret_data = {rdcollision, rddata};
    end

    // FIFO status from the extra-MSB pointers (wrap modulo 2*FIFO_DEPTH).
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
        head  = mem_q[rd_ptr_q[IW-1:0]];
    end

    // Response output selection, FIFO push/pop decisions.
    always_comb begin
        rsp_valid                 = !empty;
        {rsp_collision, rsp_data} = head;
        push                      = ret;
        fifo_pop                  = !empty && rsp_ready;
`ifdef READ_PORT_ADAPTER_BYPASS_EN
        // Empty FIFO: returning data goes straight out; it is only stored
        // when downstream cannot take it this cycle.
        if (empty && ret) begin
            rsp_valid                 = 1'b1;
            {rsp_collision, rsp_data} = ret_data;
            push                      = !rsp_ready;
        end
`endif
        push_ok = push && (!full || fifo_pop);
        rsp_pop = rsp_valid && rsp_ready;
    end

    // Next-state for pointers and the in-flight/buffered credit count.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pending_d = pending_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({accept, rsp_pop})
            2'b10:   pending_d = pending_q + PW'(1);
            2'b01:   pending_d = pending_q - PW'(1);
            default: pending_d = pending_q;
        endcase
    end

    // State registers; storage is cleared on reset so rsp_* read back as zero.
    always_ff @(posedge aclk) begin
        if (srst) begin
            pending_q <= '0;
            vld_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            vld_q     <= vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            if (push_ok) begin
                mem_q[wr_ptr_q[IW-1:0]] <= ret_data;
            end
        end
    end

endmodule

// File: tb/tb_read_port_adapter.sv
// Bench for read_port_adapter: two instances (RD_LATENCY 1 and 2) share the
// same stimulus; each has its own memory model and scoreboard.
module tb_read_port_adapter;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
`ifdef READ_PORT_ADAPTER_BYPASS_EN
    localparam int unsigned EXTRA = 0;
`else
    localparam int unsigned EXTRA = 1;
`endif

    logic          clk = 1'b0;
    logic          srst;
    logic          rv;
    logic          rsr;
    logic [AW-1:0] ra;
    logic          rr   [2];
    logic          rden [2];
    logic          rsv  [2];
    logic [AW-1:0] rda  [2];
    logic [DW-1:0] rdd  [2];
    logic [DW-1:0] rspd [2];
    logic [1:0]    rdc  [2];
    logic [1:0]    rspc [2];
    logic [2:0]    pend [2];

    logic [DW-1:0] mem_img [256];
    logic [1:0]    col_img [256];

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    int acc   [2];
    int pops  [2];
    int lat   [2];
    int stall [2];
    int first [2];
    int last  [2];
    int vcnt  [2];
    logic [1:0] colseen [2];
    int cyc;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    read_port_adapter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .FIFO_DEPTH(DEPTH)
    ) u_dut_l1 (
        .aclk(clk), .srst(srst),
        .req_valid(rv), .req_ready(rr[0]), .req_addr(ra),
        .rden(rden[0]), .rdaddr(rda[0]), .rddata(rdd[0]), .rdcollision(rdc[0]),
        .rsp_valid(rsv[0]), .rsp_ready(rsr), .rsp_data(rspd[0]),
        .rsp_collision(rspc[0]), .pending(pend[0])
    );

    read_port_adapter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .FIFO_DEPTH(DEPTH)
    ) u_dut_l2 (
        .aclk(clk), .srst(srst),
        .req_valid(rv), .req_ready(rr[1]), .req_addr(ra),
        .rden(rden[1]), .rdaddr(rda[1]), .rddata(rdd[1]), .rdcollision(rdc[1]),
        .rsp_valid(rsv[1]), .rsp_ready(rsr), .rsp_data(rspd[1]),
        .rsp_collision(rspc[1]), .pending(pend[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int unsigned L = g + 1;

        // Memory: image lookup L cycles after rden, random noise otherwise.
        logic          v_pipe [L];
        logic [AW-1:0] a_pipe [L];
        logic [DW-1:0] noise_q;

        always @(posedge clk) begin
            v_pipe[0] <= rden[g];
            a_pipe[0] <= rda[g];
            for (int i = 1; i < int'(L); i++) begin
                v_pipe[i] <= v_pipe[i-1];
                a_pipe[i] <= a_pipe[i-1];
            end
            noise_q <= $urandom;
        end

        assign rdd[g] = (v_pipe[L-1] === 1'b1) ? mem_img[a_pipe[L-1]] : noise_q;
        assign rdc[g] = (v_pipe[L-1] === 1'b1) ? col_img[a_pipe[L-1]] : noise_q[1:0];

        // Scoreboard: expected responses in acceptance order, credit count.
        logic [DW+1:0] exp_q [$];
        int            pend_m = 0;

        always @(negedge clk) begin
            #2;
            if (srst) begin
                exp_q.delete();
                pend_m = 0;
            end else begin
                chk($sformatf("L%0d pending", L), 64'(pend[g]), 64'(pend_m));
                chk($sformatf("L%0d req_ready", L), 64'(rr[g]), 64'(pend_m < int'(DEPTH)));
                if (rsv[g]) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("L%0d spurious_rsp", L), 64'(rsv[g]), 64'(0));
                    end else begin
                        chk($sformatf("L%0d rsp", L), 64'({rspc[g], rspd[g]}), 64'(exp_q[0]));
                    end
                    if (rsr) begin
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        pend_m--;
                    end
                end
                if (rv && rr[g]) begin
                    exp_q.push_back({col_img[ra], mem_img[ra]});
                    pend_m++;
                end
            end
        end
    end

    task automatic drain();
        rv  = 1'b0;
        rsr = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic single_read(input logic [AW-1:0] addr);
        @(negedge clk);
        rv = 1'b1;
        ra = addr;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("L%0d rden_on_accept", g + 1), 64'(rden[g]), 64'(1));
            chk($sformatf("L%0d rdaddr", g + 1), 64'(rda[g]), 64'(addr));
            lat[g] = 0;
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            rv = 1'b0;
            #1;
            for (int g = 0; g < 2; g++) begin
                if (lat[g] == 0 && rsv[g]) begin
                    lat[g]     = k;
                    colseen[g] = rspc[g];
                    chk($sformatf("L%0d single_data", g + 1), 64'(rspd[g]), 64'(mem_img[addr]));
                end
            end
        end
    endtask

    initial begin
        srst = 1'b1;
        rv   = 1'b0;
        rsr  = 1'b1;
        ra   = '0;
        for (int i = 0; i < 256; i++) begin
            mem_img[i] = $urandom;
            col_img[i] = 2'($urandom_range(0, 3));
        end
        mem_img[8'h10] = 32'hCAFE0010;
        mem_img[8'h20] = 32'h1234ABCD;
        col_img[8'h20] = 2'b10;

        // Reset state
        repeat (3) @(negedge clk);
        srst = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("L%0d rst_rsp_valid", g + 1), 64'(rsv[g]), 64'(0));
            chk($sformatf("L%0d rst_rden", g + 1), 64'(rden[g]), 64'(0));
            chk($sformatf("L%0d rst_pending", g + 1), 64'(pend[g]), 64'(0));
            chk($sformatf("L%0d rst_req_ready", g + 1), 64'(rr[g]), 64'(1));
            chk($sformatf("L%0d rst_rsp_data", g + 1), 64'(rspd[g]), 64'(0));
            chk($sformatf("L%0d rst_rsp_coll", g + 1), 64'(rspc[g]), 64'(0));
        end

        // Single read latency
        single_read(8'h10);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("L%0d latency", g + 1), 64'(lat[g]), 64'(g + 1 + int'(EXTRA)));
            chk($sformatf("L%0d pending_idle", g + 1), 64'(pend[g]), 64'(0));
        end

        // Collision passthrough
        drain();
        single_read(8'h20);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("L%0d collision", g + 1), 64'(colseen[g]), 64'(2'b10));
        end

        // Backpressure: credits cap acceptance at DEPTH
        drain();
        rsr = 1'b0;
        acc = '{0, 0};
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rv = 1'b1;
            ra = AW'(c * 7);
            #1;
            for (int g = 0; g < 2; g++) if (rr[g]) acc[g]++;
        end
        @(negedge clk);
        rv = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("L%0d bp_accepted", g + 1), 64'(acc[g]), 64'(DEPTH));
            chk($sformatf("L%0d bp_ready_low", g + 1), 64'(rr[g]), 64'(0));
            chk($sformatf("L%0d bp_pending", g + 1), 64'(pend[g]), 64'(DEPTH));
        end
        rsr  = 1'b1;
        pops = '{0, 0};
        for (int c = 0; c < 12; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            for (int g = 0; g < 2; g++) if (rsv[g] && rsr) pops[g]++;
        end
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("L%0d bp_returned", g + 1), 64'(pops[g]), 64'(DEPTH));
            chk($sformatf("L%0d bp_ready_back", g + 1), 64'(rr[g]), 64'(1));
        end

        // Streaming: 64 back-to-back
        drain();
        stall = '{0, 0};
        pops  = '{0, 0};
        first = '{-1, -1};
        last  = '{-1, -1};
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            rv = (c < 64);
            ra = AW'($urandom);
            #1;
            for (int g = 0; g < 2; g++) begin
                if (rv && !rr[g]) stall[g]++;
                if (rsv[g]) begin
                    if (first[g] < 0) first[g] = c;
                    last[g] = c;
                    pops[g]++;
                end
            end
        end
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("L%0d stream_stalls", g + 1), 64'(stall[g]), 64'(0));
            chk($sformatf("L%0d stream_count", g + 1), 64'(pops[g]), 64'(64));
            chk($sformatf("L%0d stream_span", g + 1), 64'(last[g] - first[g]), 64'(63));
        end

        // Mid-operation reset with 3 reads outstanding
        drain();
        rsr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rv = 1'b1;
            ra = AW'($urandom);
        end
        @(negedge clk);
        rv   = 1'b0;
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("L%0d mrst_pending", g + 1), 64'(pend[g]), 64'(0));
            chk($sformatf("L%0d mrst_rsp_valid", g + 1), 64'(rsv[g]), 64'(0));
        end
        rsr  = 1'b1;
        vcnt = '{0, 0};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            for (int g = 0; g < 2; g++) if (rsv[g]) vcnt[g]++;
        end
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("L%0d mrst_stale", g + 1), 64'(vcnt[g]), 64'(0));
        end

        // Random traffic, 50% rsp_ready, at least 500 accepted by RD_LATENCY=2
        drain();
        acc = '{0, 0};
        cyc = 0;
        while (acc[1] < 500 && cyc < 5000) begin
            @(negedge clk);
            rv  = ($urandom_range(0, 3) != 0);
            ra  = AW'($urandom);
            rsr = ($urandom_range(0, 1) == 1);
            #1;
            for (int g = 0; g < 2; g++) if (rv && rr[g]) acc[g]++;
            cyc++;
        end
        drain();
        chk("rand_accepted", 64'(acc[1] >= 500), 64'(1));
        chk("L1 rand_no_loss", 64'(g_lane[0].exp_q.size()), 64'(0));
        chk("L2 rand_no_loss", 64'(g_lane[1].exp_q.size()), 64'(0));
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("L%0d rand_pending_end", g + 1), 64'(pend[g]), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t reached, limit 1000000", $time);
        $fatal(1);
    end

endmodule

// File: doc/read_port_adapter.md
READ_PORT_ADAPTER -- requirements
Module: read_port_adapter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, read address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, read data width in bits.
REQ-003 Parameter RD_LATENCY, default 1, memory read-port latency in cycles; legal values are 1 and 2.
REQ-004 Parameter FIFO_DEPTH, default 4, response buffer entries; SHALL be a power of two and at least 2.
REQ-005 aclk  input  1  the single clock; all logic is on its rising edge.
REQ-006 srst  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  1  the upstream read request is valid.
REQ-008 req_ready  output  1  the adapter accepts the request.
REQ-009 req_addr  input  ADDR_WIDTH  the request address.
REQ-010 rden  output  1  read enable to the memory read port.
REQ-011 rdaddr  output  ADDR_WIDTH  read address to the memory read port.
REQ-012 rddata  input  DATA_WIDTH  memory read data, valid RD_LATENCY cycles after rden.
REQ-013 rdcollision  input  2  memory collision flags, aligned with rddata.
REQ-014 rsp_valid  output  1  the response is valid.
REQ-015 rsp_ready  input  1  downstream accepts the response.
REQ-016 rsp_data  output  DATA_WIDTH  response data.
REQ-017 rsp_collision  output  2  rdcollision captured with the response.
REQ-018 pending  output  $clog2(FIFO_DEPTH)+1  reads in flight plus buffered responses.

Function
REQ-019 A request SHALL be accepted when req_valid and req_ready are both high in the same cycle.
REQ-020 On acceptance, rden SHALL be 1 and rdaddr SHALL equal req_addr combinationally in that cycle; otherwise rden SHALL be 0.
REQ-021 req_ready SHALL be high only when pending < FIFO_DEPTH, and SHALL be independent of req_valid.
REQ-022 A RD_LATENCY-deep valid shift register SHALL track issued reads; when its last stage is set, {rdcollision, rddata} SHALL be pushed into the FIFO.
REQ-023 The FIFO SHALL never overflow, because of the credit rule in REQ-021; rddata arriving with no tracked read SHALL be ignored.
REQ-024 The FIFO SHALL pop when rsp_valid and rsp_ready are both high; rsp_valid SHALL equal "FIFO not empty".
REQ-025 rsp_data and rsp_collision SHALL be held stable while rsp_valid is high and rsp_ready is low.
REQ-026 pending SHALL increment on acceptance and decrement on pop; it SHALL be unchanged when both occur in the same cycle.
REQ-027 Responses SHALL be delivered in request order.
REQ-028 A push and a pop SHALL both be able to occur when the FIFO is full, and when it is empty in bypass mode.
REQ-029 FIFO read and write pointers SHALL be $clog2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full is detected when the MSBs differ and the rest of the pointers are equal.
REQ-030 Base latency from acceptance to rsp_valid SHALL be RD_LATENCY+1 cycles.
REQ-031 Sustained throughput SHALL be one response per cycle when rsp_ready is held high.

Reset
REQ-032 While srst is high at a clock edge, the FIFO pointers, the valid shift register and pending SHALL be cleared.
REQ-033 After reset, outputs SHALL be: rsp_valid=0, rden=0, pending=0, req_ready=1.
REQ-034 rsp_data and rsp_collision SHALL be 0 after reset.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight reads and buffered responses.
REQ-036 No response SHALL be emitted for reads issued before reset.

Configuration
REQ-037 Macro READ_PORT_ADAPTER_BYPASS_EN SHALL control cut-through operation.
REQ-038 When READ_PORT_ADAPTER_BYPASS_EN is defined and the FIFO is empty, returning data SHALL drive rsp_valid, rsp_data and rsp_collision in the return cycle; latency is RD_LATENCY.
REQ-039 In bypass, if rsp_ready is high the data SHALL be consumed without a push; otherwise it SHALL be pushed.
REQ-040 When READ_PORT_ADAPTER_BYPASS_EN is undefined, all data SHALL pass through the FIFO (REQ-030 latency), and rsp_* SHALL be driven from registers only.

Verification
REQ-041 Single read: after reset, req_addr=0x10 accepted at cycle 0, rddata=0xCAFE0010 returned at cycle 1, rsp_ready=1 -> rsp_valid high at cycle 2 (cycle 1 with bypass) with rsp_data=0xCAFE0010 and pending back to 0.
REQ-042 Backpressure: rsp_ready=0 with continuous req_valid -> exactly 4 accepted, then req_ready=0 and pending=4; releasing rsp_ready -> 4 responses returned in order, then req_ready=1.
REQ-043 Streaming: 64 back-to-back requests with rsp_ready=1 -> 64 in-order responses on consecutive cycles, with no req_ready deassertion.
REQ-044 Collision passthrough: rdcollision=2'b10 returned with the data -> rsp_collision=2'b10 on that response.
REQ-045 Mid-operation reset: srst pulsed for 1 cycle with 3 reads pending -> pending=0, rsp_valid=0, and no stale responses afterwards.
REQ-046 RD_LATENCY=2: random rsp_ready at 50% over 500 requests -> every response matches a scoreboard, in order, with no loss.
